// File: rtl/caxi4interconnect_thread_tracker.sv
`default_nettype none
// ============================================================================
// Module   : caxi4interconnect_thread_tracker
// Function : Tracks open AXI transaction threads (ID -> slave, open count).
//            Gates new transactions so that an ID never has transactions
//            open to two slaves at once, bounds per-thread outstanding
//            counts, and flags completions that match no open thread.
// Revision : 1.0 - initial release
// ============================================================================
module caxi4interconnect_thread_tracker #(
  parameter int ID_WIDTH         = 4,
  parameter int NUM_SLAVES_WIDTH = 2,
  parameter int NUM_THREADS      = 4,
  parameter int OPEN_TRANS_WIDTH = 3,
  parameter int OPEN_TRANS_MAX   = 7,
  parameter int ORDER_MODE       = 0
) (
  input  logic                          sysClk,
  input  logic                          sysReset,
  input  logic                          incValid,
  input  logic [ID_WIDTH-1:0]           incID,
  input  logic [NUM_SLAVES_WIDTH-1:0]   incSlaveID,
  output logic                          incReady,
  input  logic                          decValid,
  input  logic [ID_WIDTH-1:0]           decID,
  output logic                          matchValid,
  output logic [OPEN_TRANS_WIDTH-1:0]   matchCount,
  output logic [NUM_SLAVES_WIDTH-1:0]   matchSlaveID,
  output logic [NUM_THREADS-1:0]        activeMask,
  output logic [4:0]                    freeThreads,
  output logic [OPEN_TRANS_WIDTH+3:0]   totalOpen,
  output logic                          idle,
  input  logic                          errClear,
  output logic                          errDec
);

  localparam int                      TOTAL_W = OPEN_TRANS_WIDTH + 4;
  localparam logic [OPEN_TRANS_WIDTH-1:0] CNT_MAX = OPEN_TRANS_WIDTH'(OPEN_TRANS_MAX);
  localparam logic [OPEN_TRANS_WIDTH-1:0] CNT_ONE = OPEN_TRANS_WIDTH'(1);

  // Per-slot registered state, gathered from the slot generate below
  logic [NUM_THREADS-1:0]        active;
  logic [ID_WIDTH-1:0]           tid    [NUM_THREADS];
  logic [NUM_SLAVES_WIDTH-1:0]   tslave [NUM_THREADS];
  logic [OPEN_TRANS_WIDTH-1:0]   tcnt   [NUM_THREADS];

  // Lookup results (all from registered state)
  logic [NUM_THREADS-1:0]        inc_hit_vec;
  logic [NUM_THREADS-1:0]        dec_hit_vec;
  logic [NUM_THREADS-1:0]        free_oh;
  logic                          free_found;
  logic [4:0]                    free_cnt;
  logic [OPEN_TRANS_WIDTH-1:0]   match_cnt;
  logic [NUM_SLAVES_WIDTH-1:0]   match_slave;
  logic                          slave_conflict;
  logic                          inc_hit;
  logic                          dec_hit;
  logic                          accept;
  logic                          dec_ok;
  logic                          ready;

  // ID lookups, lowest free slot, free count and cross-slot slave check
  always_comb begin
    inc_hit_vec    = '0;
    dec_hit_vec    = '0;
    free_oh        = '0;
    free_found     = 1'b0;
    free_cnt       = '0;
    match_cnt      = '0;
    match_slave    = '0;
    slave_conflict = 1'b0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      inc_hit_vec[i] = active[i] && (tid[i] == incID);
      dec_hit_vec[i] = active[i] && (tid[i] == decID);
      if (!active[i]) begin
        free_cnt = free_cnt + 5'd1;
        if (!free_found) begin
          free_oh[i] = 1'b1;
          free_found = 1'b1;
        end
      end
      // At most one slot hits per ID, so OR-ing acts as a mux
      if (inc_hit_vec[i]) begin
        match_cnt   = match_cnt | tcnt[i];
        match_slave = match_slave | tslave[i];
      end
      if (active[i] && (tslave[i] != incSlaveID)) begin
        slave_conflict = 1'b1;
      end
    end
  end

  assign inc_hit = |inc_hit_vec;
  assign dec_hit = |dec_hit_vec;

  // Acceptance: hit extends an existing thread, miss needs a free slot
  always_comb begin
    ready = 1'b0;
    if (inc_hit) begin
      ready = (match_slave == incSlaveID) && (match_cnt < CNT_MAX);
    end else begin
      ready = (free_cnt != 5'd0);
    end
    // Single-slave mode: any open thread to another slave blocks the offer
    if ((ORDER_MODE == 1) && slave_conflict) begin
      ready = 1'b0;
    end
  end

  assign incReady = ready;
  assign accept   = incValid & ready;
  assign dec_ok   = decValid & dec_hit;

  generate
    for (genvar g = 0; g < NUM_THREADS; g++) begin : g_slot
      logic                          slot_active;
      logic [ID_WIDTH-1:0]           slot_id;
      logic [NUM_SLAVES_WIDTH-1:0]   slot_slave;
      logic [OPEN_TRANS_WIDTH-1:0]   slot_cnt;
      logic                          inc_here;
      logic                          alloc_here;
      logic                          dec_here;

      assign inc_here   = accept & inc_hit_vec[g];
      assign alloc_here = accept & ~inc_hit & free_oh[g];
      assign dec_here   = decValid & dec_hit_vec[g];

      // Slot update; a same-slot accept and completion cancel out
      always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
          slot_active <= 1'b0;
          slot_id     <= '0;
          slot_slave  <= '0;
          slot_cnt    <= '0;
        end else if (alloc_here) begin
          slot_active <= 1'b1;
          slot_id     <= incID;
          slot_slave  <= incSlaveID;
          slot_cnt    <= CNT_ONE;
        end else if (inc_here && !dec_here) begin
          slot_cnt <= slot_cnt + CNT_ONE;
        end else if (dec_here && !inc_here) begin
          slot_cnt <= slot_cnt - CNT_ONE;
          if (slot_cnt == CNT_ONE) begin
            slot_active <= 1'b0;
          end
        end
      end

      assign active[g] = slot_active;
      assign tid[g]    = slot_id;
      assign tslave[g] = slot_slave;
      assign tcnt[g]   = slot_cnt;
    end
  endgenerate

  // Running total of open transactions, saturating at both ends
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      totalOpen <= '0;
    end else if (accept && !dec_ok) begin
      if (totalOpen != {TOTAL_W{1'b1}}) begin
        totalOpen <= totalOpen + TOTAL_W'(1);
      end
    end else if (dec_ok && !accept) begin
      if (totalOpen != '0) begin
        totalOpen <= totalOpen - TOTAL_W'(1);
      end
    end
  end

  // Sticky unmatched-completion flag; a new error beats a clear
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      errDec <= 1'b0;
    end else if (decValid && !dec_hit) begin
      errDec <= 1'b1;
    end else if (errClear) begin
      errDec <= 1'b0;
    end
  end

  assign activeMask   = active;
  assign freeThreads  = free_cnt;
  assign idle         = ~|active;
  assign matchValid   = inc_hit;
  assign matchCount   = match_cnt;
  assign matchSlaveID = match_slave;

endmodule
`default_nettype wire
